// File: rtl/dequantization.sv
// dequantization: multiplies 64 captured coefficients by their quantization-table entries one per cycle, saturating each product to 16 bits.
module dequantization (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 Enable,
  input  logic signed [1023:0] A,
  input  logic signed [1023:0] B,
  output logic signed [1023:0] C,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [5:0]    k_q, k_d;
  logic [1023:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic          done_q, done_d;
  logic signed [31:0] prod;
  logic [15:0]   sat;
  // the single shared multiplier, steered by k
  assign prod = $signed(a_q[{k_q, 4'b0} +: 16]) * $signed(b_q[{k_q, 4'b0} +: 16]);
  assign sat  = prod > 32'sd32767 ? 16'h7fff : prod < -32'sd32768 ? 16'h8000 : prod[15:0];
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (Enable) begin
        a_d     = A;
        b_d     = B;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        c_d[{k_q, 4'b0} +: 16] = sat;
        k_d = k_q + 6'd1;
        if (k_q == 6'd63) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: if (!Enable) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end
  assign C    = c_q;
  assign done = done_q;
endmodule

// File: doc/dequantization.md
DEQUANTIZATION -- requirements
Module: dequantization

Interface
REQ-001 The block SHALL have the port Clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising Clock edge.
REQ-003 The block SHALL have the port Enable, input, 1 bit: start request / hold-off.
REQ-004 The block SHALL have the port A, input, signed [1023:0]: 64 quantized coefficients, 16-bit signed each.
REQ-005 The block SHALL have the port B, input, signed [1023:0]: 64 quantization-table entries, 16-bit signed each.
REQ-006 The block SHALL have the port C, output, signed [1023:0]: 64 dequantized coefficients, 16-bit signed each.
REQ-007 The block SHALL have the port done, output, 1 bit: result-valid flag.
REQ-008 The block SHALL locate element (row i, col j), i,j in 0..7, of A, B and C at bits [(i*8+j)*16 +: 16]; index k = i*8+j.

Function
REQ-009 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-010 In IDLE with Enable=1 at a clock edge, the block SHALL capture A and B into internal registers, set k=0 and enter RUN; it SHALL ignore A and B changes after capture.
REQ-011 In IDLE with Enable=0, the block SHALL remain in IDLE, holding C and done=0.
REQ-012 In RUN, at each clock edge the block SHALL write C[k] = sat16(Areg[k] * Breg[k]) and increment k; only element k of C SHALL change on that edge.
REQ-013 The product SHALL be full-precision 16x16 signed (32-bit), then saturated: results >32767 become 32767, results <-32768 become -32768, all others pass unchanged.
REQ-014 After writing k=63, the block SHALL enter DONE and set done=1 on the same edge, so done rises on the 64th edge after the capture edge.
REQ-015 RUN SHALL complete all 64 elements regardless of Enable; Enable SHALL have no effect during RUN.
REQ-016 In DONE, done SHALL stay 1 and C SHALL stay stable while Enable=1.
REQ-017 In DONE with Enable=0, the next edge SHALL return the block to IDLE with done=0 and C retained.
REQ-018 A new run SHALL require Enable to be low for at least one edge after DONE; keeping Enable high SHALL NOT restart the block.
REQ-019 At the start of a new run, C SHALL NOT be cleared; it SHALL be overwritten element by element, in order of k.
REQ-020 The block SHALL use exactly one 16x16 multiplier, shared across all elements.

Reset
REQ-021 When reset=1 at a clock edge, the block SHALL enter IDLE and set done=0, C=0, k=0 and clear the internal A/B registers.
REQ-022 Reset SHALL have priority over Enable in all states.
REQ-023 A reset during RUN SHALL abort the run; the run SHALL NOT resume when reset goes low, and a fresh Enable SHALL be required to start again.
REQ-024 While reset=1, outputs SHALL stay at their reset values.

Verification
REQ-025 Nominal run: A(0,0)=10, A(0,1)=-3, A(1,0)=2, all other A=0, B = standard JPEG luminance table (B(0,0)=16, B(0,1)=11, B(1,0)=12) -> C(0,0)=160, C(0,1)=-33, C(1,0)=24, all other C=0, done=1.
REQ-026 Latency: Enable raised at a known edge -> done=0 for the next 63 edges and done=1 exactly at the 64th edge after capture; C(7,7) is written on that same edge.
REQ-027 Saturation: A(3,3)=1000, B(3,3)=100 and A(4,4)=-1000, B(4,4)=100 -> C(3,3)=32767 and C(4,4)=-32768.
REQ-028 Capture isolation and Enable behaviour: A/B changed and Enable toggled during RUN -> results match the captured values; done persists while Enable=1, clears one edge after Enable=0, and re-raising Enable yields a second correct run.
REQ-029 Reset mid-run: reset asserted at edge 20 of RUN -> C=0, done=0, IDLE; no done follows without a new Enable.
REQ-030 Round trip: quantize an 8x8 block with the existing quantization block, then feed its C and the same B to this block -> each output is within +/-B(i,j)/2 of the original coefficient.
